// File: rtl/piso_stream_tx.sv
// piso_stream_tx
// Parallel-in/serial-out transmitter for the SPI datapath. A DATA_W-bit word
// is accepted over a valid/ready handshake and shifted out one bit every
// CLK_DIV clocks. The bit order (MSB or LSB first) is chosen per word.
//
// Optional feature: define PISO_STREAM_PARITY_EN to append an even-parity bit
// (XOR of the word) after the last data bit.
//
// Ports:
//   clock        system clock, rising edge
//   n_reset      asynchronous active-low reset
//   parallel_in  word to transmit, sampled on accept
//   in_valid     parallel_in is valid
//   in_ready     block can accept a word (IDLE only)
//   msb_first    bit order for the word being accepted (1 = MSB first)
//   abort        synchronous cancel of the word in flight
//   serial_out   registered serial data, IDLE_LEVEL when idle
//   bit_strobe   one-clock pulse on the first clock of every bit period
//   busy         high while a word (or its parity bit) is being sent
//   done         one-clock pulse after a word completes without abort
module piso_stream_tx #(
  parameter int   DATA_W     = 8,
  parameter int   CLK_DIV    = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] parallel_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              msb_first,
  input  logic              abort,
  output logic              serial_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PISO_STREAM_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] shift_reg, next_shift, shifted;
  logic              msb_reg, next_msb;
  logic [CNT_W-1:0]  bit_cnt, next_cnt;
  logic [DIV_W-1:0]  div_cnt, next_div;
  logic              serial_q, next_serial;
  logic              strobe_q, next_strobe;
  logic              done_q, next_done;
`ifdef PISO_STREAM_PARITY_EN
  logic              parity_q, next_parity;
`endif

  // State and datapath registers; all outputs except busy/in_ready come
  // straight from flops so the pin driver sees glitch-free levels.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      msb_reg   <= 1'b0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      serial_q  <= IDLE_LEVEL;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef PISO_STREAM_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      shift_reg <= next_shift;
      msb_reg   <= next_msb;
      bit_cnt   <= next_cnt;
      div_cnt   <= next_div;
      serial_q  <= next_serial;
      strobe_q  <= next_strobe;
      done_q    <= next_done;
`ifdef PISO_STREAM_PARITY_EN
      parity_q  <= next_parity;
`endif
    end
  end

  // Next-state and next-output logic. The shift register moves toward the
  // end being transmitted, so the next bit is always at the same end.
  always_comb begin
    next_state  = state;
    next_shift  = shift_reg;
    next_msb    = msb_reg;
    next_cnt    = bit_cnt;
    next_div    = div_cnt;
    next_serial = serial_q;
    next_strobe = 1'b0;
    next_done   = 1'b0;
`ifdef PISO_STREAM_PARITY_EN
    next_parity = parity_q;
`endif
    shifted = msb_reg ? {shift_reg[DATA_W-2:0], 1'b0}
                      : {1'b0, shift_reg[DATA_W-1:1]};

    case (state)
      IDLE: begin
        next_serial = IDLE_LEVEL;
        // abort takes priority over a simultaneous accept
        if (in_valid && !abort) begin
          next_state  = SHIFT;
          next_shift  = parallel_in;
          next_msb    = msb_first;
          next_cnt    = '0;
          next_div    = '0;
          next_serial = msb_first ? parallel_in[DATA_W-1] : parallel_in[0];
          next_strobe = 1'b1;
`ifdef PISO_STREAM_PARITY_EN
          next_parity = ^parallel_in;
`endif
        end
      end

      SHIFT: begin
        if (abort) begin
          next_state  = IDLE;
          next_shift  = '0;
          next_cnt    = '0;
          next_div    = '0;
          next_serial = IDLE_LEVEL;
        end else if (div_cnt == DIV_LAST) begin
          next_div = '0;
          if (bit_cnt == LAST_BIT) begin
            next_cnt   = '0;
            next_shift = '0;
`ifdef PISO_STREAM_PARITY_EN
            next_state  = PARITY;
            next_serial = parity_q;
            next_strobe = 1'b1;
`else
            next_state  = IDLE;
            next_serial = IDLE_LEVEL;
            next_done   = 1'b1;
`endif
          end else begin
            next_cnt    = bit_cnt + 1'b1;
            next_shift  = shifted;
            next_serial = msb_reg ? shifted[DATA_W-1] : shifted[0];
            next_strobe = 1'b1;
          end
        end else begin
          next_div = div_cnt + 1'b1;
        end
      end

`ifdef PISO_STREAM_PARITY_EN
      PARITY: begin
        if (abort) begin
          next_state  = IDLE;
          next_div    = '0;
          next_serial = IDLE_LEVEL;
        end else if (div_cnt == DIV_LAST) begin
          next_state  = IDLE;
          next_div    = '0;
          next_serial = IDLE_LEVEL;
          next_done   = 1'b1;
        end else begin
          next_div = div_cnt + 1'b1;
        end
      end
`endif

      default: begin
        next_state  = IDLE;
        next_shift  = '0;
        next_cnt    = '0;
        next_div    = '0;
        next_serial = IDLE_LEVEL;
      end
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign serial_out = serial_q;
  assign bit_strobe = strobe_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_stream_tx.sv
// tb_piso_stream_tx
// Directed bench for piso_stream_tx. Instance a uses CLK_DIV=4, instance b
// uses CLK_DIV=1 for back-to-back traffic. Both share data/order/abort inputs
// and have separate in_valid lines. Outputs are sampled on the falling edge.
module tb_piso_stream_tx;

`ifdef PISO_STREAM_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clock = 1'b0;
  logic       n_reset;
  logic [7:0] parallel_in;
  logic       msb_first;
  logic       abort;
  logic       a_valid, b_valid;
  logic       a_ready, a_serial, a_strobe, a_busy, a_done;
  logic       b_ready, b_serial, b_strobe, b_busy, b_done;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  piso_stream_tx #(.DATA_W(8), .CLK_DIV(4), .IDLE_LEVEL(1'b0)) dut_a (
    .clock(clock), .n_reset(n_reset), .parallel_in(parallel_in),
    .in_valid(a_valid), .in_ready(a_ready), .msb_first(msb_first),
    .abort(abort), .serial_out(a_serial), .bit_strobe(a_strobe),
    .busy(a_busy), .done(a_done)
  );

  piso_stream_tx #(.DATA_W(8), .CLK_DIV(1), .IDLE_LEVEL(1'b0)) dut_b (
    .clock(clock), .n_reset(n_reset), .parallel_in(parallel_in),
    .in_valid(b_valid), .in_ready(b_ready), .msb_first(msb_first),
    .abort(abort), .serial_out(b_serial), .bit_strobe(b_strobe),
    .busy(b_busy), .done(b_done)
  );

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic msb,
                               input logic va, input logic vb, input logic ab);
    parallel_in = data;
    msb_first   = msb;
    a_valid     = va;
    b_valid     = vb;
    abort       = ab;
  endtask

  // Sends one word on instance a (use_b=0) or b (use_b=1) and checks every
  // cycle of it plus the done cycle. With keep_valid the valid line is left
  // high so the caller can chain a second word on the done cycle.
  task automatic sendWord(input logic [7:0] data, input logic msb,
                          input bit use_b, input bit keep_valid);
    int   d;
    int   nbits;
    int   k;
    int   strobes;
    logic exp_bit;
    d       = use_b ? 1 : 4;
    nbits   = 8 + PAR;
    strobes = 0;
    applyStimulus(data, msb, !use_b, use_b, 1'b0);
    @(negedge clock);
    if (!keep_valid) applyStimulus(data, msb, 1'b0, 1'b0, 1'b0);
    checkOutput("accept_in_ready", use_b ? b_ready : a_ready, 0);
    for (int c = 1; c <= nbits * d; c++) begin
      if (c > 1) @(negedge clock);
      k = (c - 1) / d;
      if (k < 8) exp_bit = msb ? data[7-k] : data[k];
      else       exp_bit = ^data;
      checkOutput($sformatf("bit%0d_c%0d", k, c), use_b ? b_serial : a_serial, exp_bit);
      checkOutput($sformatf("strobe_c%0d", c), use_b ? b_strobe : a_strobe,
                  ((c - 1) % d) == 0);
      checkOutput($sformatf("busy_c%0d", c), use_b ? b_busy : a_busy, 1);
      checkOutput($sformatf("done_low_c%0d", c), use_b ? b_done : a_done, 0);
      if ((use_b ? b_strobe : a_strobe) === 1'b1) strobes++;
    end
    checkOutput("strobe_count", strobes, nbits);
    @(negedge clock);
    checkOutput("done_pulse", use_b ? b_done : a_done, 1);
    checkOutput("done_busy", use_b ? b_busy : a_busy, 0);
    checkOutput("done_ready", use_b ? b_ready : a_ready, 1);
    checkOutput("done_idle_level", use_b ? b_serial : a_serial, 0);
  endtask

  initial begin
    n_reset = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    @(negedge clock);
    checkOutput("rst_serial", a_serial, 0);
    checkOutput("rst_busy", a_busy, 0);
    checkOutput("rst_done", a_done, 0);
    checkOutput("rst_strobe", a_strobe, 0);
    checkOutput("rst_ready", a_ready, 1);
    n_reset = 1'b1;
    @(negedge clock);

    // Bit order and single-word timing on CLK_DIV=4
    sendWord(8'hA5, 1'b1, 1'b0, 1'b0);
    sendWord(8'hA5, 1'b0, 1'b0, 1'b0);
    sendWord(8'h01, 1'b0, 1'b0, 1'b0);
    sendWord(8'h07, 1'b1, 1'b0, 1'b0);

    // Back-to-back on CLK_DIV=1: second word accepted on the done cycle
    sendWord(8'hF0, 1'b1, 1'b1, 1'b1);
    sendWord(8'h0F, 1'b0, 1'b1, 1'b0);

    // Abort 10 clocks after accept
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clock);
    checkOutput("pre_abort_busy", a_busy, 1);
    checkOutput("pre_abort_serial", a_serial, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checkOutput("abort_busy", a_busy, 0);
    checkOutput("abort_ready", a_ready, 1);
    checkOutput("abort_done", a_done, 0);
    checkOutput("abort_serial", a_serial, 0);
    @(negedge clock);
    checkOutput("abort_no_late_done", a_done, 0);
    sendWord(8'h3C, 1'b1, 1'b0, 1'b0);

    // abort and in_valid together in IDLE: no accept
    applyStimulus(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_abort_busy", a_busy, 0);
    checkOutput("idle_abort_strobe", a_strobe, 0);
    checkOutput("idle_abort_ready", a_ready, 1);

    // Asynchronous reset mid-word
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("midword_busy", a_busy, 1);
    checkOutput("midword_serial", a_serial, 1);
    n_reset = 1'b0;
    #1;
    checkOutput("async_rst_serial", a_serial, 0);
    checkOutput("async_rst_busy", a_busy, 0);
    checkOutput("async_rst_done", a_done, 0);
    checkOutput("async_rst_ready", a_ready, 1);
    @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_done", a_done, 0);
    checkOutput("post_rst_busy", a_busy, 0);
    checkOutput("post_rst_ready", a_ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/piso_stream_tx.md
# piso_stream_tx

Parametrised parallel-in/serial-out transmitter for the SPI interface datapath: accepts a DATA_W-bit word over a valid/ready handshake, shifts it out one bit every CLK_DIV clocks in a per-word selectable bit order, and reports progress through busy, bit_strobe and done. It sits between the register/command logic and the SPI pin driver. It has a synchronous abort and an optional trailing parity bit.

## Interface
- DATA_W, 8: word width in bits, ≥2.
- CLK_DIV, 4: clocks per serial bit, ≥1.
- IDLE_LEVEL, 1'b0: serial_out level while idle or after abort.
- clock  input  1  system clock, all logic on rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- parallel_in  input  DATA_W  word to transmit, sampled on accept.
- in_valid  input  1  parallel_in is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- msb_first  input  1  bit order, sampled on accept (1 = MSB first).
- abort  input  1  synchronous cancel of the current word.
- serial_out  output  1  serial data, registered.
- bit_strobe  output  1  one-clock pulse on the first clock of each bit period (data and parity bits).
- busy  output  1  high while in SHIFT or PARITY.
- done  output  1  one-clock pulse after a word (and parity) completes normally.

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- Reset: state=IDLE, serial_out=IDLE_LEVEL, in_ready=1 after reset release, busy=0, bit_strobe=0, done=0, shift register, bit counter and divider=0.
- Accept: in_valid & in_ready at an edge. The block latches parallel_in and msb_first, goes to SHIFT, and drives the first bit on serial_out.
- SHIFT: the divider counts 0..CLK_DIV-1. When it wraps, the next bit is presented and the bit counter increments.
- Bit order: MSB first sends bit DATA_W-1 down to 0. LSB first sends bit 0 up to DATA_W-1.
- After bit DATA_W-1 (or bit 0 for MSB first) has been held for CLK_DIV clocks:
  - with parity, go to PARITY;
  - otherwise go to IDLE with done=1 for one clock.
- IDLE: serial_out=IDLE_LEVEL, in_ready=1. parallel_in is ignored unless in_valid is high.
- abort=1 in SHIFT or PARITY: next state IDLE, serial_out=IDLE_LEVEL, no done pulse, counters cleared.
- abort and in_valid both high in IDLE: abort wins, no accept.
- Counter widths: bit counter $clog2(DATA_W), divider max(1, $clog2(CLK_DIV)). No other arithmetic.

## Timing
- Accept edge at T: at T+1 busy=1, in_ready=0, bit_strobe=1, serial_out=first bit.
- Bit k is on serial_out from T+1+k·CLK_DIV through T+(k+1)·CLK_DIV.
- Word without parity: busy high for DATA_W·CLK_DIV clocks. At T+1+DATA_W·CLK_DIV: busy=0, in_ready=1, done=1, serial_out=IDLE_LEVEL.
- With parity, add CLK_DIV clocks before done.
- Back-to-back: a new word may be accepted on the done cycle. Minimum inter-word gap is 1 clock at IDLE_LEVEL.
- Abort asserted at edge A: at A+1 busy=0, in_ready=1, done=0.
- Reset mid-word: all outputs return to reset values immediately (asynchronous). No done pulse.

## Configuration
- PISO_STREAM_PARITY_EN defined:
  - PARITY state is present and is entered after the last data bit.
  - serial_out = XOR of the latched word (even parity) for CLK_DIV clocks, with a bit_strobe at the start.
  - done follows the parity bit.
  - abort applies in PARITY as in SHIFT.
- Not defined: no PARITY state, no parity logic, timing as for a word without parity.

## Test plan
- Reset: n_reset low mid-word with 8'hA5 in flight -> serial_out=IDLE_LEVEL, busy=0, done=0, in_ready=1 after release.
- DATA_W=8, CLK_DIV=4, msb_first=1, word 8'hA5 -> bits 1,0,1,0,0,1,0,1, each 4 clocks wide. 8 bit_strobes; done at accept+33; busy for 32 clocks.
- Same word with msb_first=0 -> bits 1,0,1,0,0,1,0,1 (palindromic check). Then word 8'h01 -> bits 1,0,0,0,0,0,0,0.
- CLK_DIV=1, two words 8'hF0 and 8'h0F with in_valid held -> second accepted on the done cycle; exactly one IDLE_LEVEL clock between words.
- Abort: word 8'hFF, abort asserted 10 clocks after accept -> IDLE next clock, no done, a new word 8'h3C then sends correctly.
- PISO_STREAM_PARITY_EN, word 8'h07 -> 8 data bits, then parity bit 1 for CLK_DIV clocks, done at accept+1+9·CLK_DIV.
